scalar_mult_sequencer: RTL and testbench

- Computes Q = k·P over the prime field p by left-to-right double-and-add.
- Sits directly upstream of the affine point-operation engine (point add and point double) and drives it through a start/done handshake. It passes operands in and consumes each returned point.
- Handles the cases the add engine does not: identical operands, opposite points and the point at infinity.
- Its output feeds the ECDSA sign/verify controller.

---
 rtl/scalar_mult_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_scalar_mult_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/scalar_mult_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : scalar_mult_sequencer
//  Purpose  : Left-to-right double-and-add Q = k*P over an external affine
//             point engine; resolves infinity, equal and opposite operands.
//  Revision : 1.0 - initial release
// ============================================================================
module scalar_mult_sequencer #(
    parameter int N = 256
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] k,
    input  logic [N-1:0] px,
    input  logic [N-1:0] py,
    input  logic [N-1:0] p,
    output logic         op_start,
    output logic         op_dbl,
    output logic [N-1:0] op_x1,
    output logic [N-1:0] op_y1,
    output logic [N-1:0] op_x2,
    output logic [N-1:0] op_y2,
    input  logic         op_done,
    input  logic [N-1:0] op_x3,
    input  logic [N-1:0] op_y3,
    input  logic         op_inf,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] qx,
    output logic [N-1:0] qy,
    output logic         q_inf
);

    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] c_IDX_TOP = IW'(N - 1);

    localparam logic [3:0] c_IDLE     = 4'd0;
    localparam logic [3:0] c_SCAN     = 4'd1;
    localparam logic [3:0] c_DBL_REQ  = 4'd2;
    localparam logic [3:0] c_DBL_WAIT = 4'd3;
    localparam logic [3:0] c_ADD_CHK  = 4'd4;
    localparam logic [3:0] c_ADD_REQ  = 4'd5;
    localparam logic [3:0] c_ADD_WAIT = 4'd6;
    localparam logic [3:0] c_NEXT     = 4'd7;
    localparam logic [3:0] c_FINISH   = 4'd8;

    logic [3:0]    r_state;
    logic [N-1:0]  r_k, r_px, r_py, r_rx, r_ry;
    logic          r_rinf;
    logic [IW-1:0] r_idx;
    logic          r_busy, r_done, r_op_dbl, r_q_inf;
    logic [N-1:0]  r_op_x1, r_op_y1, r_op_x2, r_op_y2, r_qx, r_qy;
    logic          w_bit;
    logic          w_unused_p;

    assign w_bit      = r_k[r_idx];
    // The prime is consumed by the point engine, not by the sequencer.
    assign w_unused_p = ^p;

    assign op_start = (r_state == c_DBL_REQ) || (r_state == c_ADD_REQ);
    assign op_dbl   = r_op_dbl;
    assign op_x1    = r_op_x1;
    assign op_y1    = r_op_y1;
    assign op_x2    = r_op_x2;
    assign op_y2    = r_op_y2;
    assign busy     = r_busy;
    assign done     = r_done;
    assign qx       = r_qx;
    assign qy       = r_qy;
    assign q_inf    = r_q_inf;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= c_IDLE;
            r_k      <= '0;
            r_px     <= '0;
            r_py     <= '0;
            r_rx     <= '0;
            r_ry     <= '0;
            r_rinf   <= 1'b1;
            r_idx    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_op_dbl <= 1'b0;
            r_op_x1  <= '0;
            r_op_y1  <= '0;
            r_op_x2  <= '0;
            r_op_y2  <= '0;
            r_qx     <= '0;
            r_qy     <= '0;
            r_q_inf  <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_k     <= k;
                        r_px    <= px;
                        r_py    <= py;
                        r_idx   <= c_IDX_TOP;
                        r_rinf  <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= c_SCAN;
                    end
                end
                c_SCAN: begin
                    // Leading zeros and the first set bit cost one cycle each
                    // with no engine traffic, so the index step is folded in.
                    if (r_rinf) begin
                        if (w_bit) begin
                            r_rx   <= r_px;
                            r_ry   <= r_py;
                            r_rinf <= 1'b0;
                        end
                        if (r_idx == '0) begin
                            r_state <= c_FINISH;
                        end else begin
                            r_idx   <= r_idx - 1'b1;
                            r_state <= c_SCAN;
                        end
                    end else begin
                        r_op_dbl <= 1'b1;
                        r_op_x1  <= r_rx;
                        r_op_y1  <= r_ry;
                        r_state  <= c_DBL_REQ;
                    end
                end
                c_DBL_REQ: r_state <= c_DBL_WAIT;
                c_DBL_WAIT: begin
                    if (op_done) begin
                        if (w_bit && op_inf) begin
                            r_rx    <= r_px;
                            r_ry    <= r_py;
                            r_rinf  <= 1'b0;
                            r_state <= c_NEXT;
                        end else begin
                            r_rx    <= op_x3;
                            r_ry    <= op_y3;
                            r_rinf  <= op_inf;
                            r_state <= w_bit ? c_ADD_CHK : c_NEXT;
                        end
                    end
                end
                c_ADD_CHK: begin
                    if (r_rx != r_px) begin
                        r_op_dbl <= 1'b0;
                        r_op_x1  <= r_rx;
                        r_op_y1  <= r_ry;
                        r_op_x2  <= r_px;
                        r_op_y2  <= r_py;
                        r_state  <= c_ADD_REQ;
                    end else if (r_ry == r_py) begin
                        r_op_dbl <= 1'b1;
                        r_op_x1  <= r_rx;
                        r_op_y1  <= r_ry;
                        r_state  <= c_ADD_REQ;
                    end else begin
                        r_rinf  <= 1'b1;
                        r_state <= c_NEXT;
                    end
                end
                c_ADD_REQ: r_state <= c_ADD_WAIT;
                c_ADD_WAIT: begin
                    if (op_done) begin
                        r_rx    <= op_x3;
                        r_ry    <= op_y3;
                        r_rinf  <= op_inf;
                        r_state <= c_NEXT;
                    end
                end
                c_NEXT: begin
                    if (r_idx == '0) begin
                        r_state <= c_FINISH;
                    end else begin
                        r_idx   <= r_idx - 1'b1;
                        r_state <= c_SCAN;
                    end
                end
                c_FINISH: begin
                    r_qx    <= r_rinf ? '0 : r_rx;
                    r_qy    <= r_rinf ? '0 : r_ry;
                    r_q_inf <= r_rinf;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= c_IDLE;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_scalar_mult_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_scalar_mult_sequencer
//  Purpose  : Scalar multiply on y^2 = x^3 + 2x + 2 mod 17 with P = (5,1),
//             driven through a 3-cycle behavioural point engine.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_scalar_mult_sequencer;

    localparam int N = 8;

    typedef struct packed {
        logic       inf;
        logic [7:0] x;
        logic [7:0] y;
    } pt_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [N-1:0] k, px, py, p;
    logic         op_start, op_dbl;
    logic [N-1:0] op_x1, op_y1, op_x2, op_y2;
    logic         op_done;
    logic [N-1:0] op_x3, op_y3;
    logic         op_inf;
    logic         busy, done;
    logic [N-1:0] qx, qy;
    logic         q_inf;

    int n_chk = 0;
    int n_err = 0;
    int ops   = 0;

    always #5 clk = ~clk;

    scalar_mult_sequencer #(.N(N)) dut (
        .clk(clk), .reset(reset), .start(start), .k(k), .px(px), .py(py), .p(p),
        .op_start(op_start), .op_dbl(op_dbl),
        .op_x1(op_x1), .op_y1(op_y1), .op_x2(op_x2), .op_y2(op_y2),
        .op_done(op_done), .op_x3(op_x3), .op_y3(op_y3), .op_inf(op_inf),
        .busy(busy), .done(done), .qx(qx), .qy(qy), .q_inf(q_inf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int md(input int v);
        return ((v % 17) + 17) % 17;
    endfunction

    function automatic int inv(input int v);
        for (int i = 1; i < 17; i++)
            if (md(i * v) == 1) return i;
        return 0;
    endfunction

    // Full affine group law, including infinity and inverse operands.
    function automatic pt_t ec_add(input pt_t a, input pt_t b);
        pt_t r;
        int  lam, x1, y1, x2, y2, x3;
        r = '0;
        if (a.inf) return b;
        if (b.inf) return a;
        x1 = int'(a.x); y1 = int'(a.y); x2 = int'(b.x); y2 = int'(b.y);
        if (x1 == x2) begin
            if (y1 != y2 || y1 == 0) begin
                r.inf = 1'b1;
                return r;
            end
            lam = md(md(3 * x1 * x1 + 2) * inv(md(2 * y1)));
        end else begin
            lam = md(md(y2 - y1) * inv(md(x2 - x1)));
        end
        x3  = md(lam * lam - x1 - x2);
        r.x = 8'(x3);
        r.y = 8'(md(lam * (x1 - x3) - y1));
        return r;
    endfunction

    function automatic pt_t ref_mul(input int kk);
        pt_t g, r;
        g = '0; g.x = 8'd5; g.y = 8'd1;
        r = '0; r.inf = 1'b1;
        for (int i = 0; i < kk; i++) r = ec_add(r, g);
        return r;
    endfunction

    always @(negedge clk) if (op_start) ops++;

    // Point engine: fixed latency, answers even after the requester is reset.
    initial begin
        pt_t a, b, res;
        op_done = 1'b0; op_x3 = '0; op_y3 = '0; op_inf = 1'b0;
        forever begin
            @(negedge clk);
            if (op_start === 1'b1) begin
                a = '0; a.x = op_x1; a.y = op_y1;
                b = '0; b.x = op_dbl ? op_x1 : op_x2; b.y = op_dbl ? op_y1 : op_y2;
                res = ec_add(a, b);
                repeat (2) @(negedge clk);
                op_done = 1'b1; op_x3 = res.x; op_y3 = res.y; op_inf = res.inf;
                @(negedge clk);
                op_done = 1'b0;
            end
        end
    end

    task automatic run(input logic [7:0] kk, input bit poke, output int cyc, output int nops);
        int  ops0;
        bit  seen;
        @(negedge clk);
        ops0  = ops;
        start = 1'b1;
        k     = kk;
        cyc   = 0;
        seen  = 1'b0;
        while (cyc < 3000 && !seen) begin
            @(posedge clk);
            #1;
            cyc++;
            if (poke && cyc == 4) begin
                start = 1'b1;
                k     = 8'd1;
            end else begin
                start = 1'b0;
            end
            if (poke && cyc == 6) chk("busy_hold", busy, 1);
            if (done) seen = 1'b1;
        end
        if (!seen) chk("done_timeout", 0, 1);
        nops = ops - ops0;
        @(posedge clk);
        #1;
        chk("done_one_cycle", done, 0);
    endtask

    task automatic run_chk(input string tag, input logic [7:0] kk);
        int  cyc, nops;
        pt_t e;
        e = ref_mul(int'(kk));
        run(kk, 1'b0, cyc, nops);
        chk({tag, "_inf"}, q_inf, e.inf);
        chk({tag, "_qx"}, qx, e.inf ? 8'd0 : e.x);
        chk({tag, "_qy"}, qy, e.inf ? 8'd0 : e.y);
    endtask

    initial begin
        int cyc, nops, wait_cnt, n_done, n_busy;
        reset = 1'b0; start = 1'b0; k = '0; px = 8'd5; py = 8'd1; p = 8'd17;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_qinf", q_inf, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        run(8'd0, 1'b0, cyc, nops);
        chk("k0_latency", cyc, N + 2);
        chk("k0_inf", q_inf, 1);
        chk("k0_qx", qx, 0);
        chk("k0_qy", qy, 0);
        chk("k0_ops", nops, 0);

        run(8'd1, 1'b0, cyc, nops);
        chk("k1_q", {q_inf, qx, qy}, {1'b0, 8'd5, 8'd1});
        chk("k1_ops", nops, 0);

        run(8'd2, 1'b0, cyc, nops);
        chk("k2_q", {q_inf, qx, qy}, {1'b0, 8'd6, 8'd3});
        chk("k2_ops", nops, 1);

        run(8'd5, 1'b1, cyc, nops);
        chk("k5_q", {q_inf, qx, qy}, {1'b0, 8'd9, 8'd16});
        chk("k5_ops", nops, 3);

        // Abort a multiply while the engine holds a double request.
        @(negedge clk);
        start = 1'b1; k = 8'd2;
        @(negedge clk);
        start = 1'b0;
        wait_cnt = 0;
        while (op_start !== 1'b1 && wait_cnt < 50) begin
            @(negedge clk);
            wait_cnt++;
        end
        if (wait_cnt >= 50) chk("rst_op_timeout", 0, 1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_dbl", op_dbl, 0);
        chk("mid_rst_opstart", op_start, 0);
        chk("mid_rst_ops", {op_x1, op_y1, op_x2, op_y2}, 0);
        chk("mid_rst_q", {q_inf, qx, qy}, 0);
        @(negedge clk);
        reset = 1'b1;
        n_done = 0; n_busy = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) n_done++;
            if (busy) n_busy++;
        end
        chk("late_opdone_done", n_done, 0);
        chk("late_opdone_busy", n_busy, 0);

        run(8'd3, 1'b0, cyc, nops);
        chk("k3_q", {q_inf, qx, qy}, {1'b0, 8'd10, 8'd6});
        chk("k3_ops", nops, 2);

        run(8'd19, 1'b0, cyc, nops);
        chk("k19_q", {q_inf, qx, qy}, {1'b1, 8'd0, 8'd0});
        chk("k19_ops", nops, 5);

        run_chk("k18", 8'd18);
        for (int i = 0; i < 8; i++) run_chk("rand", 8'($urandom_range(1, 255)));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
